id_decode_buf: RTL and testbench

Parametrised decode stage for the multi-cycle/pipelined MIPS core. It sits between fetch and execute and adds a DEPTH-entry instruction queue with valid/ready handshakes on both sides. It decodes each instruction into optype/op and register addresses, and reads operands from an internal register file with write-back bypass. While an instruction is held at a stalled output, its operands are refreshed by later write-backs.

---
 rtl/id_pkg.sv | 143 ++++++++++++++
 rtl/id_regfile.sv | 34 +++
 rtl/id_decode_buf.sv | 180 ++++++++++++++++++
 tb/tb_id_decode_buf.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Decode-stage constants (instruction classes, ALU op codes) and the MIPS instruction decoder.
package id_pkg;

  localparam logic [5:0] OPT_RR      = 6'h00;
  localparam logic [5:0] OPT_SHAMT   = 6'h01;
  localparam logic [5:0] OPT_CLX     = 6'h02;
  localparam logic [5:0] OPT_IMMS    = 6'h04;
  localparam logic [5:0] OPT_IMMZ    = 6'h05;
  localparam logic [5:0] OPT_LUI     = 6'h06;
  localparam logic [5:0] OPT_JR      = 6'h10;
  localparam logic [5:0] OPT_J       = 6'h11;
  localparam logic [5:0] OPT_BR      = 6'h12;
  localparam logic [5:0] OPT_LW      = 6'h13;
  localparam logic [5:0] OPT_SW      = 6'h14;
  localparam logic [5:0] OPT_ERET    = 6'h20;
  localparam logic [5:0] OPT_SYSCALL = 6'h21;
  localparam logic [5:0] OPT_NOP     = 6'h3F;

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_ADD  = 5'h01;
  localparam logic [4:0] OP_SUB  = 5'h02;
  localparam logic [4:0] OP_AND  = 5'h03;
  localparam logic [4:0] OP_OR   = 5'h04;
  localparam logic [4:0] OP_XOR  = 5'h05;
  localparam logic [4:0] OP_NOR  = 5'h06;
  localparam logic [4:0] OP_BGTZ = 5'h07;
  localparam logic [4:0] OP_BGEZ = 5'h08;
  localparam logic [4:0] OP_BLTZ = 5'h09;
  localparam logic [4:0] OP_BLEZ = 5'h0A;
  localparam logic [4:0] OP_BEQ  = 5'h0B;
  localparam logic [4:0] OP_BNE  = 5'h0C;
  localparam logic [4:0] OP_SLL  = 5'h0D;
  localparam logic [4:0] OP_SRL  = 5'h0E;
  localparam logic [4:0] OP_SRA  = 5'h0F;
  localparam logic [4:0] OP_LUI  = 5'h10;
  localparam logic [4:0] OP_LI   = 5'h11;
  localparam logic [4:0] OP_JR   = 5'h12;
  localparam logic [4:0] OP_J    = 5'h13;
  localparam logic [4:0] OP_CLO  = 5'h1E;
  localparam logic [4:0] OP_CLZ  = 5'h1F;

  localparam logic [31:0] IR_ERET    = 32'h4200_0018;
  localparam logic [31:0] IR_SYSCALL = 32'h0000_000C;

  typedef struct packed {
    logic [5:0]  optype;
    logic [4:0]  op;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  wa;
    logic [31:0] imm;
    logic        rti;
    logic        syscall;
  } dec_t;

  function automatic logic alu_b_is_imm(input logic [5:0] optype);
    return optype inside {OPT_SHAMT, OPT_IMMS, OPT_IMMZ, OPT_LUI, OPT_J, OPT_LW, OPT_SW};
  endfunction

  // Class/op first, then the class alone selects register fields and immediate form.
  function automatic dec_t decode(input logic [31:0] ir);
    dec_t       d;
    logic [5:0] opc;
    logic [5:0] fn;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    opc = ir[31:26];
    fn  = ir[5:0];
    rs  = ir[25:21];
    rt  = ir[20:16];
    rd  = ir[15:11];
    d        = '0;
    d.optype = OPT_NOP;
    d.op     = OP_NOP;
    if (ir == IR_ERET) begin
      d.optype = OPT_ERET;
      d.rti    = 1'b1;
    end else if (ir == IR_SYSCALL) begin
      d.optype  = OPT_SYSCALL;
      d.op      = OP_JR;
      d.syscall = 1'b1;
    end else if (ir != '0) begin
      case (opc)
        6'h00: begin
          case (fn)
            6'h20, 6'h21: begin d.optype = OPT_RR;    d.op = OP_ADD; end
            6'h22, 6'h23: begin d.optype = OPT_RR;    d.op = OP_SUB; end
            6'h24:        begin d.optype = OPT_RR;    d.op = OP_AND; end
            6'h25:        begin d.optype = OPT_RR;    d.op = OP_OR;  end
            6'h26:        begin d.optype = OPT_RR;    d.op = OP_XOR; end
            6'h27:        begin d.optype = OPT_RR;    d.op = OP_NOR; end
            6'h04:        begin d.optype = OPT_RR;    d.op = OP_SLL; end
            6'h06:        begin d.optype = OPT_RR;    d.op = OP_SRL; end
            6'h07:        begin d.optype = OPT_RR;    d.op = OP_SRA; end
            6'h00:        begin d.optype = OPT_SHAMT; d.op = OP_SLL; end
            6'h02:        begin d.optype = OPT_SHAMT; d.op = OP_SRL; end
            6'h03:        begin d.optype = OPT_SHAMT; d.op = OP_SRA; end
            6'h08:        begin d.optype = OPT_JR;    d.op = OP_JR;  end
            default: ;
          endcase
        end
        6'h1C: begin
          if (fn == 6'h21) begin d.optype = OPT_CLX; d.op = OP_CLO; end
          if (fn == 6'h20) begin d.optype = OPT_CLX; d.op = OP_CLZ; end
        end
        6'h08, 6'h09: begin d.optype = OPT_IMMS; d.op = OP_ADD;  end
        6'h0C:        begin d.optype = OPT_IMMZ; d.op = OP_AND;  end
        6'h0D:        begin d.optype = OPT_IMMZ; d.op = OP_OR;   end
        6'h0E:        begin d.optype = OPT_IMMZ; d.op = OP_XOR;  end
        6'h0F:        begin d.optype = OPT_LUI;  d.op = OP_LUI;  end
        6'h02:        begin d.optype = OPT_J;    d.op = OP_J;    end
        6'h04:        begin d.optype = OPT_BR;   d.op = OP_BEQ;  end
        6'h05:        begin d.optype = OPT_BR;   d.op = OP_BNE;  end
        6'h06:        begin d.optype = OPT_BR;   d.op = OP_BLEZ; end
        6'h07:        begin d.optype = OPT_BR;   d.op = OP_BGTZ; end
        6'h01: begin
          if (rt == 5'd0) begin d.optype = OPT_BR; d.op = OP_BLTZ; end
          if (rt == 5'd1) begin d.optype = OPT_BR; d.op = OP_BGEZ; end
        end
        6'h23:        begin d.optype = OPT_LW;   d.op = OP_ADD;  end
        6'h2B:        begin d.optype = OPT_SW;   d.op = OP_ADD;  end
        default: ;
      endcase
    end
    case (d.optype)
      OPT_RR:          begin d.ra1 = rs; d.ra2 = rt; d.wa = rd; end
      OPT_SHAMT:       begin d.ra1 = rt; d.wa = rd; d.imm = {27'd0, ir[10:6]}; end
      OPT_CLX:         begin d.ra1 = rs; d.wa = rd; end
      OPT_IMMS, OPT_LW: begin d.ra1 = rs; d.wa = rt; d.imm = {{16{ir[15]}}, ir[15:0]}; end
      OPT_IMMZ:        begin d.ra1 = rs; d.wa = rt; d.imm = {16'd0, ir[15:0]}; end
      OPT_LUI:         begin d.wa = rt; d.imm = {16'd0, ir[15:0]}; end
      OPT_JR:          d.ra1 = rs;
      OPT_J:           d.imm = {4'd0, ir[25:0], 2'b00};
      OPT_BR:          begin d.ra1 = rs; d.ra2 = rt; end
      OPT_SW:          begin d.ra1 = rs; d.ra2 = rt; d.imm = {{16{ir[15]}}, ir[15:0]}; end
      OPT_SYSCALL:     d.ra1 = 5'd2;
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// 2-read/1-write register file, register 0 hardwired to zero; combinational reads.
// A read of the address being written this cycle returns the write data (write-through).
module id_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [AW-1:0]   raddr1_i,
  input  logic [AW-1:0]   raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o
);

  logic [XLEN-1:0] regs_q [NREG];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == '0) ? '0 :
                    (we_i && (waddr_i == raddr1_i)) ? wdata_i : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 :
                    (we_i && (waddr_i == raddr2_i)) ? wdata_i : regs_q[raddr2_i];

endmodule

// File: rtl/id_decode_buf.sv
// Decode stage: DEPTH-entry fetch queue feeding a decoded output register; push-to-valid is 1 cycle.
// if_ready drops only on a full queue (registered count); a stalled output keeps its operands fresh.
module id_decode_buf
  import id_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int NREG  = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    if_valid_i,
  output logic                    if_ready_o,
  input  logic [XLEN-1:0]         if_pc_i,
  input  logic [31:0]             if_ir_i,
  input  logic                    wb_we_i,
  input  logic [$clog2(NREG)-1:0] wb_addr_i,
  input  logic [XLEN-1:0]         wb_data_i,
  output logic                    id_valid_o,
  input  logic                    id_ready_i,
  output logic [XLEN-1:0]         id_pc_o,
  output logic [31:0]             id_ir_o,
  output logic [5:0]              id_optype_o,
  output logic [4:0]              id_op_o,
  output logic [$clog2(NREG)-1:0] id_ra1_o,
  output logic [$clog2(NREG)-1:0] id_ra2_o,
  output logic [$clog2(NREG)-1:0] id_wa_o,
  output logic [XLEN-1:0]         id_alu_a_o,
  output logic [XLEN-1:0]         id_alu_b_o,
  output logic [XLEN-1:0]         id_swdata_o,
  output logic                    id_rti_o,
  output logic                    id_syscall_o
);

  localparam int AW = $clog2(NREG);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     ir;
    logic [5:0]      optype;
    logic [4:0]      op;
    logic [AW-1:0]   ra1;
    logic [AW-1:0]   ra2;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] swdata;
    logic            rti;
    logic            syscall;
  } id_t;

  logic [XLEN-1:0] pc_mem_q [DEPTH];
  logic [31:0]     ir_mem_q [DEPTH];
  logic [PW:0]     count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  id_t             id_q, id_d;
  logic            id_valid_q, id_valid_d;

  logic            push;
  logic            issue;
  dec_t            head_dec;
  logic [AW-1:0]   head_ra1, head_ra2, head_wa;
  logic [XLEN-1:0] head_imm;
  logic [XLEN-1:0] rd1, rd2;
  logic            wb_hit1, wb_hit2;

  assign if_ready_o = (count_q != (PW+1)'(DEPTH));
  assign push       = if_valid_i && if_ready_o && !flush_i;
  assign issue      = (count_q != '0) && (!id_valid_q || id_ready_i);

  assign head_dec = decode(ir_mem_q[rd_ptr_q]);
  assign head_ra1 = head_dec.ra1[AW-1:0];
  assign head_ra2 = head_dec.ra2[AW-1:0];
  assign head_wa  = head_dec.wa[AW-1:0];
  assign head_imm = XLEN'(head_dec.imm);

  id_regfile #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_regfile (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .we_i     (wb_we_i),
    .waddr_i  (wb_addr_i),
    .wdata_i  (wb_data_i),
    .raddr1_i (head_ra1),
    .raddr2_i (head_ra2),
    .rdata1_o (rd1),
    .rdata2_o (rd2)
  );

  // Write-backs landing on the held instruction's sources while execute is stalled.
  assign wb_hit1 = wb_we_i && (wb_addr_i != '0) && (wb_addr_i == id_q.ra1);
  assign wb_hit2 = wb_we_i && (wb_addr_i != '0) && (wb_addr_i == id_q.ra2);

  always_comb begin
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    id_d       = id_q;
    id_valid_d = id_valid_q;
    if (flush_i) begin
      count_d     = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      id_valid_d  = 1'b0;
      id_d.optype = OPT_NOP;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (issue) begin
        rd_ptr_d     = rd_ptr_q + 1'b1;
        id_valid_d   = 1'b1;
        id_d.pc      = pc_mem_q[rd_ptr_q];
        id_d.ir      = ir_mem_q[rd_ptr_q];
        id_d.optype  = head_dec.optype;
        id_d.op      = head_dec.op;
        id_d.ra1     = head_ra1;
        id_d.ra2     = head_ra2;
        id_d.wa      = head_wa;
        id_d.alu_a   = rd1;
        id_d.alu_b   = alu_b_is_imm(head_dec.optype) ? head_imm : rd2;
        id_d.swdata  = rd2;
        id_d.rti     = head_dec.rti;
        id_d.syscall = head_dec.syscall;
      end else if (id_valid_q && !id_ready_i) begin
        if (wb_hit1) id_d.alu_a = wb_data_i;
        if (wb_hit2) begin
          id_d.swdata = wb_data_i;
          if (!alu_b_is_imm(id_q.optype)) id_d.alu_b = wb_data_i;
        end
      end else if (id_ready_i) begin
        id_valid_d = 1'b0;
      end
      case ({push, issue})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      pc_mem_q[wr_ptr_q] <= if_pc_i;
      ir_mem_q[wr_ptr_q] <= if_ir_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      id_valid_q  <= 1'b0;
      id_q        <= '0;
      id_q.optype <= OPT_NOP;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      id_valid_q <= id_valid_d;
      id_q       <= id_d;
    end
  end

  assign id_valid_o   = id_valid_q;
  assign id_pc_o      = id_q.pc;
  assign id_ir_o      = id_q.ir;
  assign id_optype_o  = id_q.optype;
  assign id_op_o      = id_q.op;
  assign id_ra1_o     = id_q.ra1;
  assign id_ra2_o     = id_q.ra2;
  assign id_wa_o      = id_q.wa;
  assign id_alu_a_o   = id_q.alu_a;
  assign id_alu_b_o   = id_q.alu_b;
  assign id_swdata_o  = id_q.swdata;
  assign id_rti_o     = id_q.rti;
  assign id_syscall_o = id_q.syscall;

endmodule

// File: tb/tb_id_decode_buf.sv
// Directed and random stimulus for id_decode_buf, checked each cycle against a queue/array model.
module tb_id_decode_buf;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst, flush, if_valid, wb_we, id_ready;
  logic [31:0] if_pc, if_ir, wb_data;
  logic [4:0]  wb_addr;
  logic        if_ready, id_valid, id_rti, id_syscall;
  logic [31:0] id_pc, id_ir, id_alu_a, id_alu_b, id_swdata;
  logic [5:0]  id_optype;
  logic [4:0]  id_op, id_ra1, id_ra2, id_wa;

  always #5 clk = ~clk;

  id_decode_buf #(.XLEN(32), .DEPTH(DEPTH), .NREG(32)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .if_valid_i(if_valid), .if_ready_o(if_ready), .if_pc_i(if_pc), .if_ir_i(if_ir),
    .wb_we_i(wb_we), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .id_valid_o(id_valid), .id_ready_i(id_ready), .id_pc_o(id_pc), .id_ir_o(id_ir),
    .id_optype_o(id_optype), .id_op_o(id_op),
    .id_ra1_o(id_ra1), .id_ra2_o(id_ra2), .id_wa_o(id_wa),
    .id_alu_a_o(id_alu_a), .id_alu_b_o(id_alu_b), .id_swdata_o(id_swdata),
    .id_rti_o(id_rti), .id_syscall_o(id_syscall)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: pending instructions, architectural registers, and the held instruction.
  logic [63:0] mq[$];
  logic [31:0] regs [32];
  logic        m_valid, m_rti, m_sys;
  logic [31:0] m_pc, m_ir, m_a, m_b, m_sw;
  logic [5:0]  m_ot;
  logic [4:0]  m_op, m_ra1, m_ra2, m_wa;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    assert (act === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic bit imm_src(input logic [5:0] ot);
    return ot inside {6'h01, 6'h04, 6'h05, 6'h06, 6'h11, 6'h13, 6'h14};
  endfunction

  task automatic ref_decode(input logic [31:0] ir, output logic [5:0] ot, output logic [4:0] op,
                            output logic [4:0] a1, output logic [4:0] a2, output logic [4:0] w,
                            output logic [31:0] im, output logic rti, output logic sys);
    logic [4:0]  rs, rt, rd;
    logic [31:0] sx, zx;
    rs = ir[25:21]; rt = ir[20:16]; rd = ir[15:11];
    sx = {{16{ir[15]}}, ir[15:0]};
    zx = {16'd0, ir[15:0]};
    {ot, op, a1, a2, w, im, rti, sys} = {6'h3F, 5'h00, 15'd0, 32'd0, 2'b00};
    if (ir == 32'h42000018) begin ot = 6'h20; rti = 1'b1; end
    else if (ir == 32'h0000000C) begin ot = 6'h21; op = 5'h12; a1 = 5'd2; sys = 1'b1; end
    else if (ir != 32'd0) begin
      unique case ({ir[31:26], (ir[31:26] == 6'h00 || ir[31:26] == 6'h1C) ? ir[5:0] : 6'h00})
        {6'h00, 6'h20}, {6'h00, 6'h21}: begin ot = 6'h00; op = 5'h01; {a1, a2, w} = {rs, rt, rd}; end
        {6'h00, 6'h22}, {6'h00, 6'h23}: begin ot = 6'h00; op = 5'h02; {a1, a2, w} = {rs, rt, rd}; end
        {6'h00, 6'h24}: begin ot = 6'h00; op = 5'h03; {a1, a2, w} = {rs, rt, rd}; end
        {6'h00, 6'h25}: begin ot = 6'h00; op = 5'h04; {a1, a2, w} = {rs, rt, rd}; end
        {6'h00, 6'h26}: begin ot = 6'h00; op = 5'h05; {a1, a2, w} = {rs, rt, rd}; end
        {6'h00, 6'h27}: begin ot = 6'h00; op = 5'h06; {a1, a2, w} = {rs, rt, rd}; end
        {6'h00, 6'h04}: begin ot = 6'h00; op = 5'h0D; {a1, a2, w} = {rs, rt, rd}; end
        {6'h00, 6'h06}: begin ot = 6'h00; op = 5'h0E; {a1, a2, w} = {rs, rt, rd}; end
        {6'h00, 6'h07}: begin ot = 6'h00; op = 5'h0F; {a1, a2, w} = {rs, rt, rd}; end
        {6'h00, 6'h00}: begin ot = 6'h01; op = 5'h0D; a1 = rt; w = rd; im = 32'(ir[10:6]); end
        {6'h00, 6'h02}: begin ot = 6'h01; op = 5'h0E; a1 = rt; w = rd; im = 32'(ir[10:6]); end
        {6'h00, 6'h03}: begin ot = 6'h01; op = 5'h0F; a1 = rt; w = rd; im = 32'(ir[10:6]); end
        {6'h00, 6'h08}: begin ot = 6'h10; op = 5'h12; a1 = rs; end
        {6'h1C, 6'h21}: begin ot = 6'h02; op = 5'h1E; a1 = rs; w = rd; end
        {6'h1C, 6'h20}: begin ot = 6'h02; op = 5'h1F; a1 = rs; w = rd; end
        {6'h08, 6'h00}, {6'h09, 6'h00}: begin ot = 6'h04; op = 5'h01; a1 = rs; w = rt; im = sx; end
        {6'h0C, 6'h00}: begin ot = 6'h05; op = 5'h03; a1 = rs; w = rt; im = zx; end
        {6'h0D, 6'h00}: begin ot = 6'h05; op = 5'h04; a1 = rs; w = rt; im = zx; end
        {6'h0E, 6'h00}: begin ot = 6'h05; op = 5'h05; a1 = rs; w = rt; im = zx; end
        {6'h0F, 6'h00}: begin ot = 6'h06; op = 5'h10; w = rt; im = zx; end
        {6'h02, 6'h00}: begin ot = 6'h11; op = 5'h13; im = {4'd0, ir[25:0], 2'b00}; end
        {6'h04, 6'h00}: begin ot = 6'h12; op = 5'h0B; a1 = rs; a2 = rt; end
        {6'h05, 6'h00}: begin ot = 6'h12; op = 5'h0C; a1 = rs; a2 = rt; end
        {6'h06, 6'h00}: begin ot = 6'h12; op = 5'h0A; a1 = rs; a2 = rt; end
        {6'h07, 6'h00}: begin ot = 6'h12; op = 5'h07; a1 = rs; a2 = rt; end
        {6'h01, 6'h00}: if (rt < 5'd2) begin ot = 6'h12; op = (rt == 5'd0) ? 5'h09 : 5'h08; a1 = rs; a2 = rt; end
        {6'h23, 6'h00}: begin ot = 6'h13; op = 5'h01; a1 = rs; w = rt; im = sx; end
        {6'h2B, 6'h00}: begin ot = 6'h14; op = 5'h01; a1 = rs; a2 = rt; im = sx; end
        default: ;
      endcase
    end
  endtask

  task automatic m_step();
    logic [63:0] e;
    logic [31:0] im;
    bit          wr, push, issue;
    int          sz;
    if (rst) begin
      mq.delete();
      for (int r = 0; r < 32; r++) regs[r] = '0;
      {m_valid, m_rti, m_sys, m_pc, m_ir, m_a, m_b, m_sw, m_op, m_ra1, m_ra2, m_wa} = '0;
      m_ot = 6'h3F;
      return;
    end
    wr = wb_we && (wb_addr != 5'd0);
    if (wr) regs[wb_addr] = wb_data;
    if (flush) begin
      mq.delete();
      m_valid = 1'b0;
      m_ot    = 6'h3F;
      return;
    end
    sz    = mq.size();
    push  = if_valid && (sz != DEPTH);
    issue = (sz != 0) && (!m_valid || id_ready);
    if (issue) begin
      e    = mq.pop_front();
      m_pc = e[63:32];
      m_ir = e[31:0];
      ref_decode(m_ir, m_ot, m_op, m_ra1, m_ra2, m_wa, im, m_rti, m_sys);
      m_a     = regs[m_ra1];
      m_sw    = regs[m_ra2];
      m_b     = imm_src(m_ot) ? im : regs[m_ra2];
      m_valid = 1'b1;
    end else if (m_valid && !id_ready) begin
      if (wr && wb_addr == m_ra1) m_a = wb_data;
      if (wr && wb_addr == m_ra2) begin
        m_sw = wb_data;
        if (!imm_src(m_ot)) m_b = wb_data;
      end
    end else if (id_ready) begin
      m_valid = 1'b0;
    end
    if (push) mq.push_back({if_pc, if_ir});
  endtask

  task automatic compare();
    chk("if_ready", if_ready, mq.size() != DEPTH);
    chk("id_valid", id_valid, m_valid);
    chk("id_decode", {id_pc, id_ir, id_optype, id_op, id_ra1, id_ra2, id_wa, id_rti, id_syscall},
                     {m_pc, m_ir, m_ot, m_op, m_ra1, m_ra2, m_wa, m_rti, m_sys});
    chk("id_operands", {id_alu_a, id_alu_b, id_swdata}, {m_a, m_b, m_sw});
  endtask

  task automatic tick();
    m_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  function automatic logic [31:0] gen_ir();
    logic [65:0] rfn = {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h04, 6'h06, 6'h07};
    logic [4:0]  rs  = 5'($urandom_range(0, 7));
    logic [4:0]  rt  = 5'($urandom_range(0, 7));
    logic [4:0]  rd  = 5'($urandom_range(0, 7));
    logic [15:0] i16 = 16'($urandom);
    case ($urandom_range(0, 15))
      0:  return {6'h00, rs, rt, rd, 5'd0, rfn[6*$urandom_range(0, 10) +: 6]};
      1:  return {6'h00, 5'd0, rt, rd, 5'($urandom), 6'($urandom_range(2, 3))};
      2:  return {6'h00, rs, 15'd0, 6'h08};
      3:  return {6'h1C, rs, rt, rd, 5'd0, 6'($urandom_range(32, 33))};
      4:  return {6'($urandom_range(8, 9)), rs, rt, i16};
      5:  return {6'($urandom_range(12, 14)), rs, rt, i16};
      6:  return {6'h0F, 5'd0, rt, i16};
      7:  return {6'h02, 26'($urandom)};
      8:  return {6'($urandom_range(4, 7)), rs, rt, i16};
      9:  return {6'h01, rs, 5'($urandom_range(0, 2)), i16};
      10: return {6'h23, rs, rt, i16};
      11: return {6'h2B, rs, rt, i16};
      12: return 32'h42000018;
      13: return 32'h0000000C;
      14: return 32'h00000000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    {flush, if_valid, wb_we, id_ready} = '0;
    {if_pc, if_ir, wb_data, wb_addr} = '0;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_valid", id_valid, 1'b0);
    chk("rst_if_ready", if_ready, 1'b1);
    chk("rst_optype", id_optype, 6'h3F);
    chk("rst_outputs", {id_pc, id_ir, id_alu_a, id_alu_b, id_swdata, id_wa, id_rti}, '0);
    rst = 1'b0;

    // addi $1,$0,5 : valid one edge after the push edge
    if_valid = 1'b1; if_pc = 32'h100; if_ir = 32'h20010005;
    tick();
    chk("addi_not_yet", id_valid, 1'b0);
    if_valid = 1'b0;
    tick();
    chk("addi_valid", id_valid, 1'b1);
    chk("addi_optype", id_optype, 6'h04);
    chk("addi_op", id_op, 5'h01);
    chk("addi_wa", id_wa, 5'd1);
    chk("addi_alu_b", id_alu_b, 32'd5);
    id_ready = 1'b1;
    tick();

    // fill with execute stalled: output + DEPTH queued, fourth offer refused
    id_ready = 1'b0;
    if_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if_pc = 32'h200 + 32'(4 * k);
      if_ir = (k == 0) ? 32'h34030011 : (k == 1) ? 32'h00000000 : (k == 2) ? 32'h3C04ABCD : 32'h8C050008;
      tick();
    end
    chk("full_if_ready", if_ready, 1'b0);
    if_valid = 1'b0;
    id_ready = 1'b1;
    chk("drain_0", id_ir, 32'h34030011);
    tick();
    chk("drain_1", id_ir, 32'h00000000);
    tick();
    chk("drain_2", id_ir, 32'h3C04ABCD);
    tick();
    chk("drain_empty", id_valid, 1'b0);

    // stalled add $3,$1,$2 picks up later write-backs
    id_ready = 1'b0; if_valid = 1'b1; if_ir = 32'h00221820;
    tick();
    if_valid = 1'b0;
    tick();
    wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'h1234;
    tick();
    chk("hold_alu_a", id_alu_a, 32'h1234);
    wb_addr = 5'd2; wb_data = 32'h55;
    tick();
    chk("hold_alu_b", id_alu_b, 32'h55);
    wb_we = 1'b0; id_ready = 1'b1;
    tick();

    // sw $2,4($0) issued in the cycle $2 is written back
    if_valid = 1'b1; if_ir = 32'hAC020004;
    tick();
    if_valid = 1'b0; wb_we = 1'b1; wb_addr = 5'd2; wb_data = 32'd7;
    tick();
    chk("sw_swdata", id_swdata, 32'd7);
    chk("sw_alu_b", id_alu_b, 32'd4);
    wb_we = 1'b0;
    tick();

    // flush with a held instruction, two queued, and a simultaneous push
    id_ready = 1'b0; if_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if_ir = 32'h20420001 + 32'(k);
      tick();
    end
    flush = 1'b1; if_ir = 32'h3C05FFFF;
    tick();
    chk("flush_valid", id_valid, 1'b0);
    chk("flush_if_ready", if_ready, 1'b1);
    chk("flush_optype", id_optype, 6'h3F);
    flush = 1'b0; if_valid = 1'b0; id_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("flush_quiet", id_valid, 1'b0);
    end

    // eret then syscall
    if_valid = 1'b1; if_ir = 32'h42000018;
    tick();
    if_ir = 32'h0000000C;
    tick();
    if_valid = 1'b0;
    chk("eret_rti", {id_rti, id_optype}, {1'b1, 6'h20});
    tick();
    chk("syscall_flag", {id_syscall, id_optype, id_ra1}, {1'b1, 6'h21, 5'd2});
    tick();

    // random traffic with one mid-stream reset
    for (int i = 0; i < 800; i++) begin
      rst      = (i == 400);
      flush    = ($urandom_range(0, 19) == 0);
      if_valid = ($urandom_range(0, 3) != 0);
      if_pc    = $urandom;
      if_ir    = gen_ir();
      wb_we    = $urandom_range(0, 1) == 1;
      wb_addr  = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      id_ready = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
